// File: rtl/apu_reg_writer.sv
// Triangle-channel register writer: parses address/data byte pairs from the serial
// receiver into the triangle registers and runs the APU frame sequencer ($4017).
module apu_reg_writer #(
    parameter int FRAME_DIV = 7457,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_4008,
    output logic [7:0] reg_400A,
    output logic [7:0] reg_400B,
    output logic       reg_event,
    output logic       enable_240hz,
    output logic       enable_120hz
);

    localparam int DW = $clog2(FRAME_DIV);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_index;
    logic            r_addr_ok;
    logic [TW-1:0]   r_tcnt;
    logic            w_write;
    logic            w_wr_4008;
    logic            w_wr_400A;
    logic            w_wr_400B;
    logic            w_wr_4017;

    logic            r_mode;
    logic [DW-1:0]   r_div;
    logic [2:0]      r_step;
    logic            w_tc;
    logic            w_last_step;
    logic            w_q_step;
    logic            w_h_step;

    // Parser state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ADDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Parser next state; a valid strobe takes priority over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        case (r_state)
            ST_ADDR: begin
                if (rx_valid) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_write     = r_addr_ok;
                    w_state_nxt = ST_ADDR;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_ADDR;
            end
        endcase
    end

    // Address latch and inter-byte timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index   <= 5'd0;
            r_addr_ok <= 1'b0;
            r_tcnt    <= '0;
        end else if ((r_state == ST_ADDR) && rx_valid) begin
            r_index   <= rx_data[4:0];
            r_addr_ok <= (rx_data[7:5] == 3'b000) && (rx_data[4:0] <= 5'h17);
            r_tcnt    <= '0;
        end else if ((r_state == ST_DATA) && !rx_valid) begin
            r_tcnt    <= r_tcnt + TW'(1);
        end
    end

    assign w_wr_4008 = w_write && (r_index == 5'h08);
    assign w_wr_400A = w_write && (r_index == 5'h0A);
    assign w_wr_400B = w_write && (r_index == 5'h0B);
    assign w_wr_4017 = w_write && (r_index == 5'h17);

    // Triangle register file and $400B write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_4008  <= 8'h00;
            reg_400A  <= 8'h00;
            reg_400B  <= 8'h00;
            reg_event <= 1'b0;
        end else begin
            if (w_wr_4008) begin
                reg_4008 <= rx_data;
            end
            if (w_wr_400A) begin
                reg_400A <= rx_data;
            end
            if (w_wr_400B) begin
                reg_400B <= rx_data;
            end
            reg_event <= w_wr_400B;
        end
    end

    // Mode 1 is the 5-step sequence whose step 3 is silent
    assign w_tc        = (r_div == DW'(FRAME_DIV - 1));
    assign w_last_step = r_mode ? (r_step == 3'd4) : (r_step == 3'd3);
    assign w_q_step    = r_mode ? (r_step != 3'd3) : 1'b1;
    assign w_h_step    = r_mode ? ((r_step == 3'd1) || (r_step == 3'd4))
                                : ((r_step == 3'd1) || (r_step == 3'd3));

    // Frame sequencer; a $4017 write overrides a coincident terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= 1'b0;
            r_div        <= '0;
            r_step       <= 3'd0;
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
        end else if (w_wr_4017) begin
            r_mode       <= rx_data[7];
            r_div        <= '0;
            r_step       <= 3'd0;
            enable_240hz <= rx_data[7];
            enable_120hz <= rx_data[7];
        end else if (w_tc) begin
            r_div        <= '0;
            r_step       <= w_last_step ? 3'd0 : (r_step + 3'd1);
            enable_240hz <= w_q_step;
            enable_120hz <= w_h_step;
        end else begin
            r_div        <= r_div + DW'(1);
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apu_reg_writer.sv
// Directed bench for apu_reg_writer: table-driven register writes plus hand-written
// sequences for frame timing, timeout, $4017 mode switch and asynchronous reset.
module tb_apu_reg_writer;

    localparam int F = 7457;
    localparam int T = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] reg_4008;
    logic [7:0] reg_400A;
    logic [7:0] reg_400B;
    logic       reg_event;
    logic       enable_240hz;
    logic       enable_120hz;

    int n_vec = 0;
    int n_err = 0;
    int ecnt  = 0;
    int n_evt = 0;
    int q240[$];
    int q120[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    apu_reg_writer #(.FRAME_DIV(F), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reg_4008     (reg_4008),
        .reg_400A     (reg_400A),
        .reg_400B     (reg_400B),
        .reg_event    (reg_event),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Log pulse positions and register strobes away from the active edge
    always @(negedge clk) begin
        if (enable_240hz) q240.push_back(ecnt);
        if (enable_120hz) q120.push_back(ecnt);
        if (reg_event)    n_evt++;
    end

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c, input logic e);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.exp = {a, b, c, 7'd0, e};
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_q(input string name, input int act[$], input int exp[$]);
        chk({name, "_count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) chk($sformatf("%s_%0d", name, i), act[i], exp[i]);
        end
    endtask

    function automatic logic [31:0] regs();
        return {reg_4008, reg_400A, reg_400B, 7'd0, reg_event};
    endfunction

    initial begin
        int e;
        int n0;

        tbl.push_back(mk(1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h81, 8'h81, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 8'h81, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h0A, 8'h81, 8'h00, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'hFD, 8'h81, 8'hFD, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h0B, 8'h81, 8'hFD, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h08, 8'h81, 8'hFD, 8'h08, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 8'h81, 8'hFD, 8'h08, 1'b0));
        tbl.push_back(mk(1'b1, 8'h0B, 8'h81, 8'hFD, 8'h08, 1'b0));
        tbl.push_back(mk(1'b1, 8'h04, 8'h81, 8'hFD, 8'h04, 1'b1));
        tbl.push_back(mk(1'b1, 8'h0B, 8'h81, 8'hFD, 8'h04, 1'b0));
        tbl.push_back(mk(1'b1, 8'h05, 8'h81, 8'hFD, 8'h05, 1'b1));
        tbl.push_back(mk(1'b1, 8'h1F, 8'h81, 8'hFD, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h55, 8'h81, 8'hFD, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h0A, 8'h81, 8'hFD, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h11, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'hE8, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h99, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h03, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h77, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h18, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h44, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h08, 8'h81, 8'h11, 8'h05, 1'b0));
        tbl.push_back(mk(1'b1, 8'h22, 8'h22, 8'h11, 8'h05, 1'b0));

        // Reset state and idle 4-step frame timing
        tick(3);
        chk("reset_outputs", {regs(), 6'd0, enable_240hz, enable_120hz}, 38'd0);
        rst = 1'b0;
        tick(4 * F + 2);
        check_q("idle_q240", q240, '{F, 2 * F, 3 * F, 4 * F});
        check_q("idle_q120", q120, '{2 * F, 4 * F});
        chk("idle_regs", regs(), 32'd0);

        // Register write vectors
        for (int i = 0; i < tbl.size(); i++) begin
            rx_valid = tbl[i].v;
            rx_data  = tbl[i].d;
            tick(1);
            chk($sformatf("vec_%0d", i), regs(), tbl[i].exp);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(1);

        // Abandoned pair after TIMEOUT idle cycles
        n0 = n_evt;
        send(8'h0B);
        tick(T);
        send(8'h0A);
        send(8'h33);
        tick(1);
        chk("timeout_400B", reg_400B, 8'h05);
        chk("timeout_400A", reg_400A, 8'h33);
        chk("timeout_no_event", n_evt - n0, 0);

        // Data arriving on the last allowed cycle is still accepted
        send(8'h0B);
        tick(T - 1);
        send(8'h5A);
        chk("timeout_edge_400B", {reg_400B, 7'd0, reg_event}, {8'h5A, 8'h01});
        tick(1);

        // Switch to 5-step mode mid-step
        tick(100);
        send(8'h17);
        q240.delete();
        q120.delete();
        send(8'h80);
        e = ecnt;
        chk("mode1_immediate", {enable_240hz, enable_120hz}, 2'b11);
        tick(5 * F + 3);
        check_q("mode1_q240", q240, '{e, e + F, e + 2 * F, e + 3 * F, e + 5 * F});
        check_q("mode1_q120", q120, '{e, e + 2 * F, e + 5 * F});

        // Back to 4-step: no immediate pulse
        send(8'h17);
        q240.delete();
        q120.delete();
        send(8'h00);
        tick(10);
        chk("mode0_no_pulse", q240.size() + q120.size(), 0);

        // Asynchronous reset while a pair is pending
        send(8'h0B);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {regs(), 6'd0, enable_240hz, enable_120hz}, 38'd0);
        tick(2);
        rst = 1'b0;
        q240.delete();
        q120.delete();
        send(8'h08);
        chk("post_reset_addr", {reg_400B, 7'd0, reg_event}, 16'h0000);
        send(8'h66);
        chk("post_reset_4008", reg_4008, 8'h66);
        tick(F + 2 - ecnt);
        check_q("post_reset_q240", q240, '{F});
        check_q("post_reset_q120", q120, '{});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
